// File: rtl/countdown_timer_if.sv
// Bus bundle for countdown_timer: load/control inputs from the sequencer,
// registered count/status back to it.
interface countdown_timer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             reload_mode;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output load, load_value, enable, reload_mode,
        input  count, busy, done
    );

    modport slave (
        input  load, load_value, enable, reload_mode,
        output count, busy, done
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle terminal-count pulse and optional
// auto-reload from the last loaded (clamped) value.
module countdown_timer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_AMOUNT = 69
) (
    input  logic                  clk,
    input  logic                  reset,
    countdown_timer_if.slave      bus
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_AMOUNT);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] rl_q,    rl_d;
    logic             done_q,  done_d;
    logic             busy_q,  busy_d;
    logic [WIDTH-1:0] clamped_v;

    always_comb begin
        clamped_v = (bus.load_value > MAX_V) ? MAX_V : bus.load_value;
    end

    // A load wins over an expiry on the same edge, so the pulse is suppressed.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rl_d    = rl_q;
        done_d  = 1'b0;
        if (bus.load) begin
            rl_d    = clamped_v;
            count_d = clamped_v;
            state_d = (clamped_v != '0) ? RUN : IDLE;
        end else if (state_q == RUN && bus.enable) begin
            if (count_q == ONE) begin
                done_d = 1'b1;
                if (bus.reload_mode) begin
                    count_d = rl_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q - ONE;
            end
        end
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            rl_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rl_q    <= rl_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    a_count_ceiling: assert property (@(posedge clk) disable iff (reset)
        count_q <= MAX_V);
    a_run_nonzero: assert property (@(posedge clk) disable iff (reset)
        (state_q == RUN) |-> (count_q != '0));
endmodule

// File: tb/tb_countdown_timer.sv
// Directed test-plan sequences plus randomized traffic, every cycle compared
// against a plain behavioural model of the timer.
module tb_countdown_timer;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned MAXA  = 69;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    countdown_timer_if #(.WIDTH(WIDTH)) bus ();

    countdown_timer #(
        .WIDTH      (WIDTH),
        .MAX_AMOUNT (MAXA)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_count = 0;
    int m_rl    = 0;
    bit m_run   = 0;
    int m_done  = 0;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit ld, input int lv,
                              input bit en, input bit rm);
        int v;
        if (rst) begin
            m_count = 0; m_rl = 0; m_run = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (ld) begin
            v       = (lv > MAXA) ? MAXA : lv;
            m_rl    = v;
            m_count = v;
            m_run   = (v != 0);
        end else if (m_run && en) begin
            if (m_count == 1) begin
                m_done = 1;
                if (rm) m_count = m_rl;
                else begin
                    m_count = 0;
                    m_run   = 0;
                end
            end else begin
                m_count = m_count - 1;
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit ld, input int lv,
                       input bit en, input bit rm);
        @(negedge clk);
        reset           = rst;
        bus.load        = ld;
        bus.load_value  = WIDTH'(lv);
        bus.enable      = en;
        bus.reload_mode = rm;
        @(posedge clk);
        model_edge(rst, ld, lv, en, rm);
        #1;
        check("model_count", bus.count, m_count);
        check("model_busy",  bus.busy,  int'(m_run));
        check("model_done",  bus.done,  m_done);
    endtask

    initial begin
        int c1[6]  = '{5, 4, 3, 2, 1, 0};
        int c2[10] = '{3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
        int e4[6]  = '{1, 0, 0, 1, 1, 1};
        int c4[6]  = '{3, 3, 3, 2, 1, 0};
        int lv;
        bit ld, en, rm, rst;

        reset = 1'b1;
        bus.load = 1'b0; bus.load_value = '0; bus.enable = 1'b0; bus.reload_mode = 1'b0;

        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        check("reset_count", bus.count, 0);
        check("reset_busy",  bus.busy,  0);
        check("reset_done",  bus.done,  0);

        // Load 5, stop mode
        for (int i = 0; i < 6; i++) begin
            cyc(0, i == 0, 5, 1, 0);
            check("t1_count", bus.count, c1[i]);
            check("t1_done",  bus.done,  (i == 5) ? 1 : 0);
            check("t1_busy",  bus.busy,  (i == 5) ? 0 : 1);
        end
        cyc(0, 0, 0, 1, 0);
        check("t1_hold_count", bus.count, 0);
        check("t1_hold_done",  bus.done,  0);

        // Load 3, reload mode
        for (int i = 0; i < 10; i++) begin
            cyc(0, i == 0, 3, 1, 1);
            check("t2_count", bus.count, c2[i]);
            check("t2_done",  bus.done,  (i == 3 || i == 6 || i == 9) ? 1 : 0);
        end

        // Clamp and zero load
        cyc(0, 1, 200, 0, 0);
        check("t3_clamp_count", bus.count, 69);
        check("t3_clamp_busy",  bus.busy,  1);
        cyc(0, 1, 0, 1, 0);
        check("t3_zero_count", bus.count, 0);
        check("t3_zero_busy",  bus.busy,  0);
        check("t3_zero_done",  bus.done,  0);

        // Pause via enable
        cyc(0, 1, 4, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, e4[i] != 0, 0);
            check("t4_count", bus.count, c4[i]);
            check("t4_done",  bus.done,  (i == 5) ? 1 : 0);
        end

        // Load on the would-be expiry edge
        cyc(0, 1, 2, 1, 0);
        cyc(0, 0, 0, 1, 0);
        check("t5_pre_count", bus.count, 1);
        cyc(0, 1, 7, 1, 0);
        check("t5_count", bus.count, 7);
        check("t5_done",  bus.done,  0);
        check("t5_busy",  bus.busy,  1);

        // Reset mid-run
        cyc(0, 1, 9, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        check("t6_pre_count", bus.count, 6);
        cyc(1, 0, 0, 1, 0);
        check("t6_count", bus.count, 0);
        check("t6_busy",  bus.busy,  0);
        check("t6_done",  bus.done,  0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1);
        check("t6_idle_count", bus.count, 0);
        check("t6_idle_busy",  bus.busy,  0);

        // Back-to-back pulses with rl=1
        cyc(0, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 1);
            check("b2b_done",  bus.done,  1);
            check("b2b_count", bus.count, 1);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            ld  = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       lv = $urandom_range(0, 3);
                1:       lv = $urandom_range(0, 12);
                2:       lv = $urandom_range(60, 80);
                default: lv = $urandom_range(0, 65535);
            endcase
            en = ($urandom_range(0, 3) != 0);
            rm = $urandom_range(0, 1);
            cyc(rst, ld, lv, en, rm);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

- Loadable down-counter with terminal-count pulse and optional auto-reload; the counterpart of the team's up-counter.
- Software or a sequencer loads a tick count and gates decrementing with `enable`.
- The block signals expiry on `done` and either stops or reloads.
- Used as the timeout/interval source beside the up-counter in the counter subsystem, and formally checked against a reference model in the same style.

## Interface

Parameters:
- `WIDTH`, default 16: width of counter and load value.
- `MAX_AMOUNT`, default 69: ceiling for loaded values. Loads above it are clamped to it. Must be ≥ 1 and < 2^WIDTH.

Ports:
- `clk`, input, 1: clock; all state changes on its rising edge.
- `reset`, input, 1: reset, synchronous, active-high.
- `load`, input, 1: load strobe; samples `load_value` this edge.
- `load_value`, input, WIDTH: requested tick count.
- `enable`, input, 1: decrement permit while running.
- `reload_mode`, input, 1: 1 = on expiry, restart from the last loaded value; 0 = stop.
- `count`, output, WIDTH: remaining ticks (registered).
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: single-cycle expiry pulse (registered).

## Operation

- **Internal state.** Two states, IDLE and RUN, plus a WIDTH-bit reload register `rl`.
- **Clamp.** `v = (load_value > MAX_AMOUNT) ? MAX_AMOUNT : load_value`. The comparison is unsigned and full width.
- **Priority per edge:** reset > load > expiry/decrement > hold.
- **Reset:** state IDLE, `count`=0, `rl`=0, `busy`=0, `done`=0.
- **Load, any state:**
  - `rl`←v, `count`←v, `done`←0.
  - If v≠0, state←RUN; if v=0, state←IDLE.
  - A load on the same edge as a would-be expiry cancels the expiry; no `done` pulse.
- **RUN, `enable`=0:** hold `count`; `done`←0.
- **RUN, `enable`=1, `count`>1:** `count`←`count`−1; `done`←0.
- **RUN, `enable`=1, `count`=1 (expiry):**
  - `done`←1.
  - If `reload_mode`=1: `count`←`rl`, stay in RUN. There is no zero cycle.
  - If `reload_mode`=0: `count`←0, state←IDLE.
- **IDLE:** `count` holds; `enable` is ignored; `done`←0 unless this is an expiry edge.
- **`reload_mode` sampling.** It is sampled only on the expiry edge and may change at any time.
- **`busy` = (state==RUN).** It is registered with the state, so it drops on the same edge that sets `done` in stop mode.
- **`count` range.** `count` never wraps below 0 and never exceeds MAX_AMOUNT.

## Timing

- **Load latency.** `load` sampled at edge N → `count`=v and `busy`=(v≠0) visible after edge N.
- **Expiry timing.** With `enable` held high from edge N+1, `done` is high during the cycle after edge N+v. That is exactly v enabled edges after the load edge.
- **Pause effect.** Each cycle with `enable`=0 in RUN delays expiry by one cycle.
- **`done` pulse width.**
  - Always exactly 1 cycle per expiry.
  - Back-to-back pulses occur only when `reload_mode`=1, `rl`=1 and `enable` is held high: one pulse per cycle.
- **Reload period.** With `enable` held high, expiries occur every `rl` cycles.
- **Reset mid-run.** All outputs return to reset values on the next edge; a pending expiry is lost.
- **Load during RUN.** Restarts immediately with the new v; the old count is discarded.
- **Formal.** Once reset has been seen, `count`, `busy` and `done` must equal the reference model every cycle.

## Test plan

- Reset, then load 5, `enable`=1, `reload_mode`=0 → `count` 5,4,3,2,1,0; `done` high only in the cycle `count`=0; `busy` low from then on; `count` stays 0.
- Load 3, `reload_mode`=1, `enable`=1 for 10 cycles → `count` 3,2,1,3,2,1,3,2,1,3; `done` high in each cycle showing the reloaded 3 (3 pulses).
- Load 200 with MAX_AMOUNT=69 → `count`=69 after the load edge; load 0 → `count`=0, `busy`=0, no `done`.
- Load 4, toggle `enable` 1,0,0,1,1,1 → `count` 3,3,3,2,1,0; `done` after the 6th edge.
- Load 2, run until `count`=1 with `enable`=1, then assert `load` with 7 on the expiry edge → `count`=7, `done` stays 0, `busy`=1.
- Load 9, run 3 cycles, assert `reset` → `count`=0, `busy`=0, `done`=0 next cycle; `enable` thereafter has no effect.
